// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: walks psum rows over K tiles for one output tile and drives the accumulation-buffer ports.
// Optional macro ACC_SEQ_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module accumulator_sequencer #(
  parameter int ADDR_W = 6,
  parameter int KT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KT_W-1:0]   k_tiles,
  input  logic [ADDR_W:0]   rows,
  input  logic              psum_valid,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              zero_sel,
  output logic              fwd_sel,
  output logic              out_valid,
  output logic              busy,
  output logic              done
`ifdef ACC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] rowCnt, rowsLast;
  logic [KT_W-1:0]   ktCnt, ktLast;
  logic [ADDR_W:0]   rowsEff;
  logic [KT_W-1:0]   ktEff;
  logic              accept, lastRow, lastTile, startAcc;

  logic              s1Valid, s1Zero, s1Final;
  logic [ADDR_W-1:0] s1Addr;
  logic              prevWrValid;
  logic [ADDR_W-1:0] prevWrAddr;

  assign accept   = (state == RUN) && psum_valid;
  assign startAcc = (state == IDLE) && start;
  assign lastRow  = (rowCnt == rowsLast);
  assign lastTile = (ktCnt == ktLast);
  assign rowsEff  = (rows == '0) ? (ADDR_W+1)'(1) : rows;
  assign ktEff    = (k_tiles == '0) ? KT_W'(1) : k_tiles;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (accept && lastRow && lastTile) nextState = DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Stage 0 counters plus the one-cycle stage-1 register that carries each accepted row to its write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rowCnt      <= '0;
      ktCnt       <= '0;
      rowsLast    <= '0;
      ktLast      <= '0;
      s1Valid     <= 1'b0;
      s1Addr      <= '0;
      s1Zero      <= 1'b0;
      s1Final     <= 1'b0;
      prevWrValid <= 1'b0;
      prevWrAddr  <= '0;
    end else begin
      if (startAcc) begin
        rowsLast <= ADDR_W'(rowsEff - (ADDR_W+1)'(1));
        ktLast   <= ktEff - KT_W'(1);
        rowCnt   <= '0;
        ktCnt    <= '0;
      end else if (accept) begin
        if (lastRow) begin
          rowCnt <= '0;
          ktCnt  <= ktCnt + KT_W'(1);
        end else begin
          rowCnt <= rowCnt + ADDR_W'(1);
        end
      end
      s1Valid <= accept;
      if (accept) begin
        s1Addr  <= rowCnt;
        s1Zero  <= (ktCnt == '0);
        s1Final <= lastTile;
      end
      prevWrValid <= s1Valid;
      prevWrAddr  <= s1Addr;
    end
  end

  always_comb begin
    buf_rd_en   = accept;
    buf_rd_addr = accept ? rowCnt : '0;
    buf_wr_en   = s1Valid;
    buf_wr_addr = s1Valid ? s1Addr : '0;
    zero_sel    = s1Valid && s1Zero;
    out_valid   = s1Valid && s1Final;
    // Back-to-back writes to one address: the buffer read missed the sum still being written.
    fwd_sel     = s1Valid && prevWrValid && (s1Addr == prevWrAddr) && !s1Zero;
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

`ifdef ACC_SEQ_STALL_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stallCnt <= '0;
    else if (startAcc)
      stallCnt <= '0;
    else if ((state == RUN) && !psum_valid && (stallCnt != 16'hFFFF))
      stallCnt <= stallCnt + 16'd1;
  end

  assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Testbench for accumulator_sequencer: table of directed jobs, reset/start corner sequences and random jobs,
// all checked cycle by cycle against a row-index reference model.
`timescale 1ns/1ps
module tb_accumulator_sequencer;

  localparam int ADDR_W = 6;
  localparam int KT_W   = 8;
  localparam int MAXC   = 1024;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [KT_W-1:0]   k_tiles;
  logic [ADDR_W:0]   rows;
  logic              psum_valid;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              zero_sel;
  logic              fwd_sel;
  logic              out_valid;
  logic              busy;
  logic              done;
`ifdef ACC_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  accumulator_sequencer #(.ADDR_W(ADDR_W), .KT_W(KT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_tiles     (k_tiles),
    .rows        (rows),
    .psum_valid  (psum_valid),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .zero_sel    (zero_sel),
    .fwd_sel     (fwd_sel),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
`ifdef ACC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit validPat[MAXC];
  int accCyc[MAXC];

  typedef struct {
    int rows;
    int kTiles;
    int mode;
    int pokeAt;
    int expWr;
    int expZero;
    int expFinal;
    int expFwd;
    int expStall;
  } vecT;

  vecT vecs[8];

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rd_en"},   -1, buf_rd_en,   0);
    checkOutput({tag, "_rd_addr"}, -1, buf_rd_addr, 0);
    checkOutput({tag, "_wr_en"},   -1, buf_wr_en,   0);
    checkOutput({tag, "_wr_addr"}, -1, buf_wr_addr, 0);
    checkOutput({tag, "_zero"},    -1, zero_sel,    0);
    checkOutput({tag, "_fwd"},     -1, fwd_sel,     0);
    checkOutput({tag, "_outv"},    -1, out_valid,   0);
    checkOutput({tag, "_busy"},    -1, busy,        0);
    checkOutput({tag, "_done"},    -1, done,        0);
`ifdef ACC_SEQ_STALL_CNT_EN
    checkOutput({tag, "_stall"},   -1, stall_cnt,   0);
`endif
  endtask

  // mode: 0 continuous, 1 toggling 1/0, 2 random. pokeAt: cycle to pulse a stray start (-1 none).
  task automatic applyStimulus(input int r, input int k, input int mode, input int pokeAt,
                               output int nWr, output int nZero, output int nFinal, output int nFwd,
                               output int stalls);
    int rEff, kEff, total, nAcc, last, nCyc;
    bit v;
    bit expRd, expWr, expZ, expO, expF, expBusy, expDone;
    int expRdA, expWrA;
    rEff = (r == 0) ? 1 : r;
    kEff = (k == 0) ? 1 : k;
    total = rEff * kEff;
    nAcc = 0; stalls = 0; last = 0;
    nWr = 0; nZero = 0; nFinal = 0; nFwd = 0;
    for (int j = 0; j < MAXC && nAcc < total; j++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (j % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      validPat[j] = v;
      if (v) begin
        accCyc[nAcc] = j;
        nAcc++;
      end else begin
        stalls++;
      end
    end
    last = accCyc[total-1];
    nCyc = last + 5;
    for (int j = last + 1; j < nCyc; j++) validPat[j] = ($urandom_range(0, 1) == 1);

    @(negedge clk);
    start = 1'b1;
    rows = r[ADDR_W:0];
    k_tiles = k[KT_W-1:0];
    psum_valid = 1'b1;
    #1;
    checkOutput("start_rd_en", -1, buf_rd_en, 0);
    checkOutput("start_busy",  -1, busy,      0);

    for (int j = 0; j < nCyc; j++) begin
      @(negedge clk);
      start = (j == pokeAt) && (j <= last + 2);
      if (start) begin
        rows = 7'd7;
        k_tiles = 8'd9;
      end
      psum_valid = validPat[j];
      #1;
      expRd = 0; expRdA = 0; expWr = 0; expWrA = 0; expZ = 0; expO = 0; expF = 0;
      for (int n = 0; n < total; n++) begin
        if (accCyc[n] == j) begin
          expRd = 1;
          expRdA = n % rEff;
        end
        if (accCyc[n] + 1 == j) begin
          expWr = 1;
          expWrA = n % rEff;
          expZ = (n / rEff == 0);
          expO = (n / rEff == kEff - 1);
          expF = (n > 0) && (accCyc[n-1] + 1 == accCyc[n]) && ((n - 1) % rEff == n % rEff) && !expZ;
        end
      end
      expBusy = (j <= last + 2);
      expDone = (j == last + 2);
      checkOutput("rd_en",   j, buf_rd_en,   expRd);
      checkOutput("rd_addr", j, buf_rd_addr, expRdA);
      checkOutput("wr_en",   j, buf_wr_en,   expWr);
      checkOutput("wr_addr", j, buf_wr_addr, expWrA);
      checkOutput("zero_sel",  j, zero_sel,  expZ);
      checkOutput("out_valid", j, out_valid, expO);
      checkOutput("fwd_sel",   j, fwd_sel,   expF);
      checkOutput("busy",      j, busy,      expBusy);
      checkOutput("done",      j, done,      expDone);
      if (buf_wr_en) nWr++;
      if (buf_wr_en && zero_sel) nZero++;
      if (buf_wr_en && out_valid) nFinal++;
      if (buf_wr_en && fwd_sel) nFwd++;
    end
    start = 1'b0;
`ifdef ACC_SEQ_STALL_CNT_EN
    checkOutput("stall_cnt", -1, stall_cnt, stalls);
`endif
    $display("[TB] job rows=%0d k_tiles=%0d mode=%0d writes=%0d stalls=%0d", r, k, mode, nWr, stalls);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nWr, nZero, nFinal, nFwd, stl;
    vecs[0] = '{rows: 4,  kTiles: 3, mode: 0, pokeAt: -1, expWr: 12, expZero: 4,  expFinal: 4,  expFwd: 0, expStall: 0};
    vecs[1] = '{rows: 1,  kTiles: 4, mode: 0, pokeAt: -1, expWr: 4,  expZero: 1,  expFinal: 1,  expFwd: 3, expStall: 0};
    vecs[2] = '{rows: 3,  kTiles: 2, mode: 1, pokeAt: -1, expWr: 6,  expZero: 3,  expFinal: 3,  expFwd: 0, expStall: 5};
    vecs[3] = '{rows: 2,  kTiles: 0, mode: 0, pokeAt: -1, expWr: 2,  expZero: 2,  expFinal: 2,  expFwd: 0, expStall: 0};
    vecs[4] = '{rows: 0,  kTiles: 2, mode: 0, pokeAt: -1, expWr: 2,  expZero: 1,  expFinal: 1,  expFwd: 1, expStall: 0};
    vecs[5] = '{rows: 64, kTiles: 1, mode: 0, pokeAt: -1, expWr: 64, expZero: 64, expFinal: 64, expFwd: 0, expStall: 0};
    vecs[6] = '{rows: 3,  kTiles: 2, mode: 0, pokeAt: 2,  expWr: 6,  expZero: 3,  expFinal: 3,  expFwd: 0, expStall: 0};
    vecs[7] = '{rows: 1,  kTiles: 2, mode: 1, pokeAt: -1, expWr: 2,  expZero: 1,  expFinal: 1,  expFwd: 0, expStall: 1};

    rst_n = 1'b0; start = 1'b0; psum_valid = 1'b0; rows = '0; k_tiles = '0;
    repeat (2) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rows, vecs[i].kTiles, vecs[i].mode, vecs[i].pokeAt, nWr, nZero, nFinal, nFwd, stl);
      checkOutput($sformatf("vec%0d_writes", i), -1, nWr,    vecs[i].expWr);
      checkOutput($sformatf("vec%0d_zero", i),   -1, nZero,  vecs[i].expZero);
      checkOutput($sformatf("vec%0d_final", i),  -1, nFinal, vecs[i].expFinal);
      checkOutput($sformatf("vec%0d_fwd", i),    -1, nFwd,   vecs[i].expFwd);
`ifdef ACC_SEQ_STALL_CNT_EN
      checkOutput($sformatf("vec%0d_stall", i),  -1, stall_cnt, vecs[i].expStall);
`endif
    end

    // Reset in the middle of a rows=4 k_tiles=3 run, after the fifth row was accepted.
    @(negedge clk);
    start = 1'b1; rows = 7'd4; k_tiles = 8'd3; psum_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      start = 1'b0; psum_valid = 1'b1;
      #1;
      checkOutput("mid_rd_addr", j, buf_rd_addr, j % 4);
    end
    @(negedge clk);
    rst_n = 1'b0; psum_valid = 1'b1;
    #1;
    checkOutput("mid_wr_en",   5, buf_wr_en,   1);
    checkOutput("mid_wr_addr", 5, buf_wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1; psum_valid = 1'b1;
    #1;
    checkIdleOutputs("after_rst");
    @(negedge clk);
    psum_valid = 1'b0;
    #1;
    checkIdleOutputs("after_rst2");
    applyStimulus(2, 2, 0, -1, nWr, nZero, nFinal, nFwd, stl);
    checkOutput("restart_writes", -1, nWr, 4);

    for (int i = 0; i < 12; i++) begin
      int rr, kk, mm, pp;
      rr = $urandom_range(0, 9);
      kk = $urandom_range(0, 4);
      mm = $urandom_range(0, 2);
      pp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : -1;
      applyStimulus(rr, kk, mm, pp, nWr, nZero, nFinal, nFwd, stl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
- Sequences the partial-sum accumulator over K-dimension tiles for one output tile of the MHA systolic array.
- Streams PE-block partial sums row by row into the accumulator; generates read/write addresses for the accumulation buffer.
- Zero-selects the B operand on the first K tile; flags final sums on the last K tile.
- Sits between the systolic array's psum output and the accumulation buffer/adder bank; started by the MHA top-level controller.

Parameters:
- ADDR_W, 6, buffer row-address width; up to 2^ADDR_W rows per tile.
- KT_W, 8, width of the K-tile count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- k_tiles  input  KT_W  number of K tiles, latched at start; 0 is treated as 1.
- rows  input  ADDR_W+1  rows per tile, latched at start; legal range 1..2^ADDR_W, 0 is treated as 1.
- psum_valid  input  1  array presents one psum row this cycle.
- buf_rd_en  output  1  accumulation-buffer read enable.
- buf_rd_addr  output  ADDR_W  read address.
- buf_wr_en  output  1  buffer write enable for adder sum.
- buf_wr_addr  output  ADDR_W  write address.
- zero_sel  output  1  drive B operand to 0 (first K tile).
- fwd_sel  output  1  take B operand from the last written sum instead of buffer read data.
- out_valid  output  1  the written sum is final (last K tile).
- busy  output  1  not IDLE.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; row/tile counters 0; pipeline stage cleared. Applies mid-operation: the sequence is abandoned and no further writes occur.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> latch k_tiles/rows, row_cnt=0, kt_cnt=0 -> RUN.
  - RUN: each psum_valid cycle is stage 0.
    - Assert buf_rd_en, buf_rd_addr=row_cnt.
    - row_cnt increments; at rows-1 it wraps to 0 and kt_cnt increments.
    - After the last row of the last tile is accepted -> DRAIN.
    - psum_valid=0 stalls with no counter change.
  - DRAIN: one cycle; stage 1 completes -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Stage 1 (one cycle after each accepted row):
  - buf_wr_en=1, buf_wr_addr = registered read address.
  - zero_sel=1 iff the row belonged to tile 0.
  - out_valid=1 iff the row belonged to tile k_tiles-1.
  - Fixed latency: read-to-write = 1 cycle. The array's A path carries a matching 1-cycle delay.
- Forwarding: fwd_sel is a stage-1 signal.
  - Asserted when the current stage-1 address equals the previous stage-1 write address, that write occurred the immediately preceding cycle, and zero_sel=0.
  - This covers rows=1, where the same address is read while its previous sum is being written.
- With k_tiles=1, zero_sel and out_valid are both high on every write.
- start while busy is ignored.
- psum_valid in IDLE/DRAIN/DONE is ignored.
- busy=1 in RUN, DRAIN and DONE.

Optional Feature:
- Macro ACC_SEQ_STALL_CNT_EN.
- When defined: adds output port stall_cnt (16 bits).
  - Cleared at start.
  - Increments each RUN cycle with psum_valid=0; saturates at 0xFFFF.
  - Holds its value in IDLE; reset to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- rows=4, k_tiles=3, psum_valid continuous -> 12 reads at addresses 0,1,2,3 repeating; writes lag by 1 cycle; zero_sel high on writes 1-4, out_valid high on writes 9-12; done pulses 2 cycles after the last read.
- rows=1, k_tiles=4, continuous -> every read at addr 0; fwd_sel=1 on writes 2-4, 0 on write 1; out_valid only on write 4.
- rows=3, k_tiles=2, psum_valid toggling 1/0 -> counters advance only on valid cycles; 6 writes total; stall_cnt=5 when ACC_SEQ_STALL_CNT_EN is defined.
- k_tiles=0, rows=2 -> behaves as k_tiles=1: 2 writes, each with zero_sel=1 and out_valid=1.
- rst_n low for 1 cycle after the 5th row of a rows=4, k_tiles=3 run -> next cycle all outputs 0, state IDLE; a new start runs cleanly from addr 0.
- start pulsed during RUN -> ignored; latched rows/k_tiles unchanged, write count unchanged.
